// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 channel scheduler: R-code pairs, FSM states
// and the 16-bit command word builder.
package tlv5618_pkg;

  localparam logic [1:0] RC_A   = 2'b10;
  localparam logic [1:0] RC_B   = 2'b00;
  localparam logic [1:0] RC_BUF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Word layout: [15]=R1, [14]=SPD, [13]=PWR, [12]=R0, [11:0]=data
  function automatic logic [15:0] mk_word(input logic [1:0] rcode, input logic spd,
                                          input logic pwr, input logic [11:0] data);
    return {rcode[1], spd, pwr, rcode[0], data};
  endfunction

endpackage

// File: rtl/tlv5618_ctrl.sv
// TLV5618 channel scheduler: accepts A/B samples and power changes, sequences command
// words through the driver set_go/set_done handshake. Optional: TLV5618_CTRL_TIMEOUT_EN.
module tlv5618_ctrl
  import tlv5618_pkg::*;
#(
  parameter int DAC_W       = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [DAC_W-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [DAC_W-1:0] b_data,
  output logic             b_ready,
  input  logic             spd_fast,
  input  logic             pwr_down,
  output logic [15:0]      dac_data,
  output logic             set_go,
  input  logic             set_done,
  output logic             busy,
  output logic             upd_done,
  output logic             err_timeout
);

  state_t           state, state_next;
  logic             pwr_state;
  logic             pwr_op;
  logic             pwr_cap;
  logic             pair;
  logic [DAC_W-1:0] b_shadow;
  logic [DAC_W-1:0] a_hold;
  logic             pwr_change;
  logic             timed_out;

  assign pwr_change = (pwr_down != pwr_state);

`ifdef TLV5618_CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || state == S_ISSUE) cnt <= '0;
    else if (state == S_WAIT)    cnt <= cnt + 1'b1;
  end

  assign timed_out = (state == S_WAIT) && !set_done && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)            err_timeout <= 1'b0;
    else if (timed_out) err_timeout <= 1'b1;
  end
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    set_go     = 1'b0;
    upd_done   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        a_ready = !pwr_change;
        b_ready = !pwr_change;
        if (pwr_change || a_valid || b_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        set_go     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (set_done)       state_next = pair ? S_ISSUE : S_DONE;
        else if (timed_out) state_next = S_DONE;
      end
      S_DONE: begin
        upd_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The buffer always receives b_shadow (power word) or the new B value (pair
  // first word), so the A write that follows reloads DAC B with its current value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data  <= '0;
      pwr_state <= 1'b0;
      pwr_op    <= 1'b0;
      pwr_cap   <= 1'b0;
      pair      <= 1'b0;
      b_shadow  <= '0;
      a_hold    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pwr_change) begin
            dac_data <= mk_word(RC_BUF, spd_fast, pwr_down, b_shadow);
            pwr_op   <= 1'b1;
            pwr_cap  <= pwr_down;
            pair     <= 1'b0;
          end else if (a_valid && b_valid) begin
            dac_data <= mk_word(RC_BUF, spd_fast, pwr_state, b_data);
            b_shadow <= b_data;
            a_hold   <= a_data;
            pair     <= 1'b1;
            pwr_op   <= 1'b0;
          end else if (a_valid) begin
            dac_data <= mk_word(RC_A, spd_fast, pwr_state, a_data);
            pair     <= 1'b0;
            pwr_op   <= 1'b0;
          end else if (b_valid) begin
            dac_data <= mk_word(RC_B, spd_fast, pwr_state, b_data);
            b_shadow <= b_data;
            pair     <= 1'b0;
            pwr_op   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (set_done) begin
            if (pair) begin
              dac_data <= mk_word(RC_A, spd_fast, pwr_state, a_hold);
              pair     <= 1'b0;
            end else if (pwr_op) begin
              pwr_state <= pwr_cap;
              pwr_op    <= 1'b0;
            end
          end else if (timed_out) begin
            pair   <= 1'b0;
            pwr_op <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlv5618_ctrl.sv
// Directed bench for tlv5618_ctrl: a driver model checks each issued word against a
// scoreboard queue and answers set_go with a delayed set_done.
module tb_tlv5618_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [11:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        spd_fast = 1'b0, pwr_down = 1'b0;
  logic [15:0] dac_data;
  logic        set_go, busy, upd_done, err_timeout;
  logic        done_r = 1'b0, done_inj = 1'b0;
  logic        set_done;

  int          checks = 0, passes = 0;
  int          go_cnt = 0, upd_cnt = 0;
  int          resp_delay = 10;
  int          cd = 0;
  logic [15:0] exp_q[$];

  assign set_done = done_r | done_inj;

  always #5 clk = ~clk;

  tlv5618_ctrl #(.DAC_W(12), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .spd_fast(spd_fast), .pwr_down(pwr_down),
    .dac_data(dac_data), .set_go(set_go), .set_done(set_done),
    .busy(busy), .upd_done(upd_done), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver model: one set_done pulse resp_delay cycles after each set_go (0 = never)
  always @(negedge clk) begin
    done_r = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) done_r = 1'b1;
    end
    if (set_go) begin
      go_cnt++;
      if (exp_q.size() == 0) chk("unexpected_set_go", 32'(set_go), 32'd0);
      else chk("word", 32'(dac_data), 32'(exp_q.pop_front()));
      cd = resp_delay;
    end
    if (upd_done) upd_cnt++;
  end

  task automatic drive(input logic av, input logic [11:0] ad, input logic bv,
                       input logic [11:0] bd, input logic spd);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; spd_fast = spd;
    go_cnt = 0; upd_cnt = 0;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_upd(input string tag, input int exp_go);
    int n = 0;
    while (!upd_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_upd_seen"}, 32'(upd_done), 32'd1);
    chk({tag, "_go_count"}, 32'(go_cnt), 32'(exp_go));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_upd_once"}, 32'(upd_cnt), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dac", 32'(dac_data), 32'd0);
    chk("rst_go", 32'(set_go), 32'd0);
    chk("rst_upd", 32'(upd_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd3);

    // A-only, SPD fast: accept then set_go on the very next cycle
    exp_q.push_back(16'hC5A5);
    drive(1'b1, 12'h5A5, 1'b0, 12'h000, 1'b1);
    chk("a_latency_go", 32'(set_go), 32'd1);
    chk("a_busy_ready", 32'({busy, a_ready}), 32'h2);
    wait_upd("a_only", 1);
    chk("a_ready_back", 32'(a_ready), 32'd1);

    exp_q.push_back(16'h00FF);
    drive(1'b0, 12'h000, 1'b1, 12'h0FF, 1'b0);
    wait_upd("b_only", 1);

    exp_q.push_back(16'h8001);
    drive(1'b1, 12'h001, 1'b0, 12'h000, 1'b0);
    wait_upd("a_after_b", 1);

    // Power-down has priority over a pending A request
    pwr_down = 1'b1;
    exp_q.push_back(16'h30FF);
    exp_q.push_back(16'hA321);
    a_valid = 1'b1; a_data = 12'h321;
    go_cnt = 0; upd_cnt = 0;
    @(negedge clk);
    chk("pwr_a_blocked", 32'({a_ready, b_ready}), 32'd0);
    chk("pwr_go", 32'(set_go), 32'd1);
    begin
      int n = 0;
      while (!upd_done && n < 200) begin
        @(negedge clk);
        chk("pwr_a_blocked_wait", 32'(a_ready), 32'd0);
        n++;
      end
    end
    chk("pwr_upd", 32'(upd_done), 32'd1);
    @(negedge clk);
    chk("pwr_a_ready", 32'(a_ready), 32'd1);
    drive(1'b1, 12'h321, 1'b0, 12'h000, 1'b0);
    wait_upd("a_powered_down", 1);

    // Pair; pwr_down glitches low and back mid-transaction, which must issue nothing
    exp_q.push_back(16'h3456);
    exp_q.push_back(16'hA123);
    drive(1'b1, 12'h123, 1'b1, 12'h456, 1'b0);
    pwr_down = 1'b0;
    @(negedge clk);
    pwr_down = 1'b1;
    wait_upd("pair", 2);
    repeat (3) @(negedge clk);
    chk("glitch_no_go", 32'(go_cnt), 32'd2);

    // Power back up: word carries the shadow B value (12'h456)
    go_cnt = 0; upd_cnt = 0;
    exp_q.push_back(16'h1456);
    pwr_down = 1'b0;
    wait_upd("pwr_up", 1);

    // Reset while waiting, then a stray set_done
    resp_delay = 0;
    exp_q.push_back(16'h8777);
    drive(1'b1, 12'h777, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go_cnt = 0; upd_cnt = 0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dac", 32'(dac_data), 32'd0);
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_go", 32'(go_cnt), 32'd0);
    chk("rst_mid_no_upd", 32'(upd_cnt), 32'd0);
    chk("rst_mid_ready", 32'({a_ready, b_ready, busy}), 32'h6);

`ifdef TLV5618_CTRL_TIMEOUT_EN
    // Withheld set_done: timeout after 16 WAIT cycles, second pair word dropped
    exp_q.push_back(16'h1ABC);
    drive(1'b1, 12'h111, 1'b1, 12'hABC, 1'b0);
    wait_upd("timeout", 1);
    chk("timeout_err", 32'(err_timeout), 32'd1);
`else
    chk("no_timeout_err", 32'(err_timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
